// File: rtl/stack_pkg.sv
// stack_pkg: shared constants and typedefs for the stack storage block.
//   STACK_DEPTH : default address width (stack holds 2**STACK_DEPTH entries)
//   STACK_WIDTH : default data width of each entry
//   addr_t      : address type at the default depth
//   data_t      : data type at the default width
package stack_pkg;

  localparam int STACK_DEPTH = 4;
  localparam int STACK_WIDTH = 16;

  typedef logic [STACK_DEPTH-1:0] addr_t;
  typedef logic [STACK_WIDTH-1:0] data_t;

endpackage

// File: rtl/stack_mem.sv
// stack_mem: flip-flop register array with asynchronous clear, synchronous
// write and asynchronous read. Flops rather than RAM so that every entry can
// be cleared by reset and the read path needs no clock.
// Ports:
//   clk    : clock, writes happen on its rising edge
//   resetq : asynchronous active-low reset, clears every entry
//   ra     : read address
//   rd     : read data, entry[ra], combinational
//   we     : write enable
//   wa     : write address
//   wd     : write data
module stack_mem
  import stack_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int WIDTH = STACK_WIDTH
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic [DEPTH-1:0] ra,
  output logic [WIDTH-1:0] rd,
  input  logic             we,
  input  logic [DEPTH-1:0] wa,
  input  logic [WIDTH-1:0] wd
);

  localparam int ENTRIES = 2 ** DEPTH;

  logic [WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd = mem[ra];

endmodule

// File: rtl/stack.sv
// stack: caller-addressed stack storage (the caller owns the stack pointer;
// addresses wrap modulo 2**DEPTH with no overflow/underflow detection).
// Configuration macro:
//   STACK_BYPASS_EN : when defined, a write to the address being read is
//                     forwarded to rd in the same cycle (write-through).
//                     Forwarding is disabled while resetq is low.
// Ports:
//   clk    : clock
//   resetq : asynchronous active-low reset, clears every entry, rd reads 0
//   ra     : read address
//   rd     : read data
//   we     : write enable
//   wa     : write address
//   wd     : write data
module stack
  import stack_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int WIDTH = STACK_WIDTH
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic [DEPTH-1:0] ra,
  output logic [WIDTH-1:0] rd,
  input  logic             we,
  input  logic [DEPTH-1:0] wa,
  input  logic [WIDTH-1:0] wd
);

  logic [WIDTH-1:0] mem_rd;

  stack_mem #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_mem (
    .clk   (clk),
    .resetq(resetq),
    .ra    (ra),
    .rd    (mem_rd),
    .we    (we),
    .wa    (wa),
    .wd    (wd)
  );

`ifdef STACK_BYPASS_EN
  // Gate with resetq so a pending write cannot leak through while in reset.
  logic bypass;
  assign bypass = resetq && we && (wa == ra);
  assign rd     = bypass ? wd : mem_rd;
`else
  assign rd = mem_rd;
`endif

endmodule

// File: tb/tb_stack.sv
module tb_stack;

  localparam int DEPTH = 4;
  localparam int WIDTH = 13;
  localparam int N     = 16;

  logic             clk    = 1'b0;
  logic             resetq = 1'b0;
  logic [DEPTH-1:0] ra     = '0;
  logic [WIDTH-1:0] rd;
  logic             we     = 1'b0;
  logic [DEPTH-1:0] wa     = '0;
  logic [WIDTH-1:0] wd     = '0;

  int checks = 0;
  int errors = 0;

  // Reference: plain array of entry values, updated from the write rule.
  logic [WIDTH-1:0] model [N];

  always #5 clk = ~clk;

  stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .resetq(resetq),
    .ra    (ra),
    .rd    (rd),
    .we    (we),
    .wa    (wa),
    .wd    (wd)
  );

  function automatic logic [WIDTH-1:0] expect_rd(input logic [DEPTH-1:0] a);
    if (!resetq) return '0;
`ifdef STACK_BYPASS_EN
    if (we === 1'b1 && wa == a) return wd;
`endif
    return model[a];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) model[i] = '0;
  endfunction

  // One rising edge; the model takes the write the DUT should take.
  task automatic tick();
    @(posedge clk);
    if (resetq === 1'b1 && we === 1'b1) model[wa] = wd;
    #1;
  endtask

  task automatic write(input logic [DEPTH-1:0] a, input logic [WIDTH-1:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] got;
    resetq = 1'b1;
    tick();
    for (int i = 0; i < N; i++) write(i[DEPTH-1:0], WIDTH'($urandom) | 13'h1);
    // Assert reset mid-cycle, away from any edge.
    #2;
    resetq = 1'b0;
    model_clear();
    #1;
    ra = 4'd9;
    #0.1;
    got = rd;
    checks++;
    if (got !== 13'h0) begin
      errors++;
      $display("FAIL reset_async ra=9 got=%h want=0", got);
    end
    for (int i = 0; i < N; i++) begin
      ra = i[DEPTH-1:0];
      we = 1'b1; wa = i[DEPTH-1:0]; wd = 13'h1555;
      #0.3;
      checks++;
      if (rd !== 13'h0) begin
        errors++;
        $display("FAIL reset_read ra=%0d got=%h want=0", i, rd);
      end
    end
    we = 1'b0;
    tick();
    tick();
    resetq = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      ra = i[DEPTH-1:0];
      #1;
      checks++;
      if (rd !== 13'h0) begin
        errors++;
        $display("FAIL reset_writes_ignored ra=%0d got=%h want=0", i, rd);
      end
    end
  endtask

  task automatic test_basic();
    write(4'd1, 13'h0123);
    write(4'd2, 13'h1ABC);
    ra = 4'd1; #1;
    checks++;
    if (rd !== 13'h0123) begin errors++; $display("FAIL basic_ra1 got=%h want=0123", rd); end
    ra = 4'd2; #1;
    checks++;
    if (rd !== 13'h1ABC) begin errors++; $display("FAIL basic_ra2 got=%h want=1abc", rd); end
    ra = 4'd0; #1;
    checks++;
    if (rd !== 13'h0) begin errors++; $display("FAIL basic_ra0 got=%h want=0", rd); end
  endtask

  task automatic test_wrap();
    logic [DEPTH-1:0] p;
    p = 4'd15;
    write(p, 13'h0FFF);
    p = p + 4'd1;
    write(p, 13'h0001);
    ra = 4'd15; #1;
    checks++;
    if (rd !== 13'h0FFF) begin errors++; $display("FAIL wrap_ra15 got=%h want=0fff", rd); end
    ra = 4'd0; #1;
    checks++;
    if (rd !== 13'h0001) begin errors++; $display("FAIL wrap_ra0 got=%h want=0001", rd); end
  endtask

  task automatic test_hold();
    write(4'd3, 13'h0246);
    we = 1'b0; wa = 4'd3; wd = 13'h1FFF;
    repeat (5) tick();
    ra = 4'd3; #1;
    checks++;
    if (rd !== 13'h0246) begin errors++; $display("FAIL hold_ra3 got=%h want=0246", rd); end
    wa = 'x; wd = 'x;
    repeat (3) tick();
    wa = '0; wd = '0;
    for (int i = 0; i < N; i++) begin
      ra = i[DEPTH-1:0];
      #1;
      checks++;
      if (rd !== model[i]) begin
        errors++;
        $display("FAIL hold_x_inputs ra=%0d got=%h want=%h", i, rd, model[i]);
      end
    end
  endtask

  task automatic test_same_addr();
    logic [WIDTH-1:0] want_pre;
    write(4'd5, 13'h0011);
`ifdef STACK_BYPASS_EN
    want_pre = 13'h0AAA;
`else
    want_pre = 13'h0011;
`endif
    we = 1'b1; wa = 4'd5; ra = 4'd5; wd = 13'h0AAA;
    #1;
    checks++;
    if (rd !== want_pre) begin errors++; $display("FAIL same_addr_pre got=%h want=%h", rd, want_pre); end
    tick();
    we = 1'b0; wd = '0;
    #1;
    checks++;
    if (rd !== 13'h0AAA) begin errors++; $display("FAIL same_addr_post got=%h want=0aaa", rd); end
  endtask

  task automatic test_reset_write();
    write(4'd7, 13'h0123);
    @(negedge clk);
    we = 1'b1; wa = 4'd7; wd = 13'h0555;
    resetq = 1'b0;
    model_clear();
    tick();
    @(negedge clk);
    we = 1'b0;
    resetq = 1'b1;
    ra = 4'd7;
    #1;
    checks++;
    if (rd !== 13'h0) begin errors++; $display("FAIL reset_wins ra=7 got=%h want=0", rd); end
    // First edge after release must accept a write.
    write(4'd7, 13'h0777);
    #1;
    checks++;
    if (rd !== 13'h0777) begin errors++; $display("FAIL first_write_after_reset got=%h want=0777", rd); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] want;
    for (int n = 0; n < 400; n++) begin
      we = ($urandom_range(0, 2) != 0);
      wa = DEPTH'($urandom);
      wd = WIDTH'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : DEPTH'($urandom);
      #1;
      want = expect_rd(ra);
      checks++;
      if (rd !== want) begin
        errors++;
        $display("FAIL random n=%0d ra=%0d we=%b wa=%0d got=%h want=%h", n, ra, we, wa, rd, want);
      end
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < N; i++) begin
      ra = i[DEPTH-1:0];
      #1;
      checks++;
      if (rd !== model[i]) begin
        errors++;
        $display("FAIL random_final ra=%0d got=%h want=%h", i, rd, model[i]);
      end
    end
  endtask

  initial begin
    model_clear();
    #12;
    test_reset();
    test_basic();
    test_wrap();
    test_hold();
    test_same_addr();
    test_reset_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack.md
STACK -- requirements
Module: stack

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the address width; the stack holds 2**DEPTH entries.
REQ-002 The block SHALL have parameter WIDTH, default 16, meaning the data width of each entry.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port resetq, input, 1 bit: the reset, asynchronous, active-low.
REQ-005 The block SHALL have port ra, input, DEPTH bits: the read address.
REQ-006 The block SHALL have port rd, output, WIDTH bits: the read data.
REQ-007 The block SHALL have port we, input, 1 bit: the write enable.
REQ-008 The block SHALL have port wa, input, DEPTH bits: the write address.
REQ-009 The block SHALL have port wd, input, WIDTH bits: the write data.

Function
REQ-010 The block SHALL implement storage of 2**DEPTH entries of WIDTH bits each, addressed 0..2**DEPTH-1; the caller owns the stack pointer.
REQ-011 rd SHALL equal entry[ra] combinationally, with zero-cycle latency and no clock involvement.
REQ-012 On a rising clk edge with resetq high and we=1, entry[wa] SHALL take the value of wd; all other entries SHALL be unchanged.
REQ-013 On a rising clk edge with we=0, no entry SHALL change.
REQ-014 Addresses SHALL be used modulo 2**DEPTH; there SHALL be no overflow or underflow detection, and pointer wrap is the caller's concern.
REQ-015 With ra==wa and we=1 in the same cycle, and STACK_BYPASS_EN undefined, rd SHALL show the old entry value until the edge and the new value after it.
REQ-016 X or unknown inputs while we=0 SHALL NOT corrupt any entry.

Reset
REQ-017 While resetq is low, every entry SHALL be 0 immediately (asynchronously), independent of clk.
REQ-018 While resetq is low, rd SHALL read 0 for any ra, and writes SHALL be ignored even if we=1.
REQ-019 Reset asserted in the same cycle as a write SHALL win: the entry SHALL be 0 after reset.
REQ-020 After resetq is released, the first rising edge SHALL accept writes normally.

Configuration
REQ-021 When macro STACK_BYPASS_EN is defined and we=1 with wa==ra, rd SHALL equal wd combinationally, giving write-through forwarding; otherwise rd SHALL equal entry[ra].
REQ-022 Without STACK_BYPASS_EN there SHALL be no forwarding path; REQ-015 governs.
REQ-023 The bypass SHALL be inactive while resetq is low, so rd is 0.

Structure
REQ-024 A shared package SHALL hold the default DEPTH and WIDTH constants and the typedefs for the address (DEPTH bits) and data (WIDTH bits).
REQ-025 One sub-module, stack_mem, SHALL hold the register array with async clear, sync write and async read; the top module SHALL add only the optional bypass mux.
REQ-026 The storage SHALL be built from flip-flops rather than inferred synchronous RAM, because the read is asynchronous and reset must clear every entry.

Verification (DEPTH=4, WIDTH=13)
REQ-027 Scenario 1: assert resetq=0 mid-run -> rd=0 for ra=0..15 with no clock edge needed.
REQ-028 Scenario 2: write 0x0123 at wa=1, then 0x1ABC at wa=2; set ra=1 then ra=2 -> rd=0x0123, then rd=0x1ABC; entry 0 still reads 0.
REQ-029 Scenario 3: write 0x0FFF at wa=15, then 0x0001 at wa=0 (wrap) -> ra=15 gives 0x0FFF and ra=0 gives 0x0001.
REQ-030 Scenario 4: we=0 with wd=0x1FFF, wa=3 for 5 clocks -> ra=3 still reads its prior value.
REQ-031 Scenario 5: we=1, wa=ra=5, wd=0x0AAA, old entry 0x0011 -> before the edge rd=0x0011 (no bypass) or rd=0x0AAA (STACK_BYPASS_EN); after the edge rd=0x0AAA in both builds.
REQ-032 Scenario 6: write 0x0555 at wa=7 with resetq=0 held across the edge -> ra=7 reads 0 after release.
